image_load_avalon_master: RTL
=============================

# image_load_avalon_master

Avalon-MM read master that fetches a stored binary/low-depth image from memory and replays it as an Avalon-ST video packet. It is the downstream counterpart of the image store path: it consumes frames that the store master packed into memory, unpacks `STORE_WIDTH`-bit samples from each memory word and emits them as `DOUT_WIDTH`-bit pixels. A register slave provides the start pulse, base address and sample count.

## Interface
- `DOUT_WIDTH`, 10, output pixel width; must be ≥ `STORE_WIDTH`.
- `AVM_WIDTH_LOG`, 4, log2 of the memory word width in bits (W = 1<<`AVM_WIDTH_LOG`); W ≥ 8.
- `STORE_WIDTH`, 4, bits per stored sample; W must be a multiple of `STORE_WIDTH`. S = W/`STORE_WIDTH` samples per word.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sig_en` in 1: one-cycle start pulse.
- `sig_address` in 32: byte base address of the frame.
- `sig_sample_cnt` in 32: number of samples to replay.
- `sig_busy` out 1: high from accepted start until the last beat is accepted.
- `avm_address` out 32: read byte address.
- `avm_read` out 1: read request.
- `avm_readdata` in W: read data.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdatavalid` in 1: read data strobe.
- `dout_data` out `DOUT_WIDTH`: pixel/header data.
- `dout_valid` out 1, `dout_ready` in 1: Avalon-ST handshake.
- `dout_startofpacket`, `dout_endofpacket` out 1: packet delimiters.

## Operation
- FSM states: IDLE, HDR, REQ, WAIT, OUT.
- IDLE: `sig_en`=1 and `sig_sample_cnt`≠0 → latch address and count, clear sample counter and index → HDR (or REQ if header is disabled). `sig_en` in any other state is ignored. `sig_en` with count 0 is ignored and no packet is produced.
- HDR: `dout_valid`=1, `dout_data`=0 (type 0), SOP=1. On `dout_ready` → REQ.
- REQ: `avm_read`=1 with the current address. Hold address and read while `avm_waitrequest`=1. On accept → WAIT, and the address advances by W/8 bytes.
- WAIT: on `avm_readdatavalid` → latch the word into the buffer, index=0 → OUT. `avm_readdatavalid` outside WAIT is ignored.
- OUT: `dout_valid`=1. `dout_data` = sample[index] left-aligned, i.e. `{sample, (DOUT_WIDTH-STORE_WIDTH)'b0}`. Sample 0 is taken from word bits [STORE_WIDTH-1:0].
  - On `dout_ready`: sample counter +1.
  - If this was the last sample (counter = count-1) → EOP was 1 on this beat → IDLE.
  - Else if index = S-1 → REQ.
  - Else index+1.
  - Unused samples in the final word are discarded.
- The sample counter is 32 bits. The address is 32 bits and wraps modulo 2^32 without error.
- `sig_busy` = (state ≠ IDLE).

## Timing
- Reset values: `avm_read`=0, `avm_address`=0, `dout_valid`=0, `dout_data`=0, SOP=0, EOP=0, `sig_busy`=0, state IDLE.
- All outputs are registered.
- Start latency: `sig_en` at cycle 0 → header valid at cycle 1.
- Memory read: `avm_read` rises the cycle after the HDR beat is accepted. With zero waitrequest and readdatavalid at cycle k, the first pixel is valid at cycle k+1.
- One read outstanding at a time. One bubble-free beat per cycle within a word; a refetch gap exists between words.
- While `dout_valid`=1 and `dout_ready`=0, data, SOP and EOP remain stable.
- Reset mid-packet aborts immediately to IDLE. A truncated packet is acceptable, and stale `avm_readdatavalid` is ignored.

## Configuration
- `IMAGE_LOAD_HEADER_EN` defined: a type-0 header beat precedes the pixels and carries SOP; pixel beats have SOP=0.
- `IMAGE_LOAD_HEADER_EN` undefined: there is no HDR state; the first pixel beat carries SOP. For count 1, the single beat carries both SOP and EOP.

## Test plan
All scenarios use defaults (W=16, S=4), base 0x1000, header enabled unless stated.
- Count 4, word 0x4321, ready always 1 → header 0x000 with SOP, then pixels 0x040, 0x080, 0x0C0, 0x100, with EOP on 0x100; one read at 0x1000.
- Count 6, words 0x4321 and 0x8765 → reads at 0x1000 then 0x1002; pixels 0x040…0x100, 0x140, 0x180 with EOP; samples 7 and 8 are not emitted; `sig_busy` falls after the last beat.
- `avm_waitrequest` held for 3 cycles and `dout_ready` toggled randomly → `avm_address` and `avm_read` are stable while stalled; beat data is stable while unready; the sequence is identical to the ready-always case.
- `sig_en` during busy, and `sig_en` with count 0 → no new read and no packet; the current packet is unaffected.
- `rst_n` asserted during OUT, followed by a late `avm_readdatavalid` → outputs reset to 0; state remains IDLE; the next start produces a correct full packet.
- With `IMAGE_LOAD_HEADER_EN` undefined, count 1, word 0x000F → single beat 0x3C0 with SOP=EOP=1.

Source files
------------

// File: rtl/image_load_avalon_master.sv
// Avalon-MM read master that replays a packed low-depth image from memory as an Avalon-ST packet.
// Optional type-0 header beat is enabled by defining IMAGE_LOAD_HEADER_EN.
module image_load_avalon_master #(
    parameter int DOUT_WIDTH    = 10,
    parameter int AVM_WIDTH_LOG = 4,
    parameter int STORE_WIDTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sig_en,
    input  logic [31:0]                     sig_address,
    input  logic [31:0]                     sig_sample_cnt,
    output logic                            sig_busy,
    output logic [31:0]                     avm_address,
    output logic                            avm_read,
    input  logic [(1 << AVM_WIDTH_LOG)-1:0] avm_readdata,
    input  logic                            avm_waitrequest,
    input  logic                            avm_readdatavalid,
    output logic [DOUT_WIDTH-1:0]           dout_data,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            dout_startofpacket,
    output logic                            dout_endofpacket
);

    localparam int W     = 1 << AVM_WIDTH_LOG;
    localparam int S     = W / STORE_WIDTH;
    localparam int IDX_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [31:0]      ADDR_STEP = 32'(W / 8);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(S - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
`ifdef IMAGE_LOAD_HEADER_EN
        ST_HDR  = 3'd1,
`endif
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [31:0]             addr_r, addr_s;
    logic [31:0]             cnt_r, cnt_s;
    logic [31:0]             smp_r, smp_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [W-1:0]            buf_r, buf_s;

    logic                    read_r, read_s;
    logic                    valid_r, valid_s;
    logic [DOUT_WIDTH-1:0]   data_r, data_s;
    logic                    sop_r, sop_s;
    logic                    eop_r, eop_s;
    logic                    busy_r, busy_s;

    // Select sample idx of a word (sample 0 in the LSBs) and left-align it in the pixel.
    function automatic logic [DOUT_WIDTH-1:0] pixel_of(input logic [W-1:0] word,
                                                       input logic [IDX_W-1:0] idx);
        logic [STORE_WIDTH-1:0] smp;
        smp = '0;
        for (int i = 0; i < S; i++) begin
            if (idx == IDX_W'(i)) begin
                smp = word[i*STORE_WIDTH +: STORE_WIDTH];
            end else begin
                smp = smp;
            end
        end
        pixel_of = '0;
        pixel_of[DOUT_WIDTH-1 -: STORE_WIDTH] = smp;
    endfunction

    // Next-state and datapath update logic.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        cnt_s   = cnt_r;
        smp_s   = smp_r;
        idx_s   = idx_r;
        buf_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (sig_en && (sig_sample_cnt != 32'd0)) begin
                    addr_s  = sig_address;
                    cnt_s   = sig_sample_cnt;
                    smp_s   = 32'd0;
                    idx_s   = '0;
`ifdef IMAGE_LOAD_HEADER_EN
                    state_s = ST_HDR;
`else
                    state_s = ST_REQ;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
`ifdef IMAGE_LOAD_HEADER_EN
            ST_HDR: begin
                if (dout_ready) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HDR;
                end
            end
`endif
            ST_REQ: begin
                if (!avm_waitrequest) begin
                    addr_s  = addr_r + ADDR_STEP;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (avm_readdatavalid) begin
                    buf_s   = avm_readdata;
                    idx_s   = '0;
                    state_s = ST_OUT;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (dout_ready) begin
                    smp_s = smp_r + 32'd1;
                    if (smp_r == (cnt_r - 32'd1)) begin
                        state_s = ST_IDLE;
                    end else if (idx_r == IDX_LAST) begin
                        state_s = ST_REQ;
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                        state_s = ST_OUT;
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values decoded from the next state so every port comes straight from a flop.
    always_comb begin
        read_s  = (state_s == ST_REQ);
        busy_s  = (state_s != ST_IDLE);
        eop_s   = 1'b0;
        data_s  = '0;
`ifdef IMAGE_LOAD_HEADER_EN
        valid_s = (state_s == ST_HDR) || (state_s == ST_OUT);
        sop_s   = (state_s == ST_HDR);
`else
        valid_s = (state_s == ST_OUT);
        sop_s   = (state_s == ST_OUT) && (smp_s == 32'd0);
`endif
        if (state_s == ST_OUT) begin
            data_s = pixel_of(buf_s, idx_s);
            eop_s  = (smp_s == (cnt_s - 32'd1));
        end else begin
            data_s = '0;
            eop_s  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            addr_r  <= 32'd0;
            cnt_r   <= 32'd0;
            smp_r   <= 32'd0;
            idx_r   <= '0;
            buf_r   <= '0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            cnt_r   <= cnt_s;
            smp_r   <= smp_s;
            idx_r   <= idx_s;
            buf_r   <= buf_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= '0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            read_r  <= read_s;
            valid_r <= valid_s;
            data_r  <= data_s;
            sop_r   <= sop_s;
            eop_r   <= eop_s;
            busy_r  <= busy_s;
        end
    end

    assign avm_address        = addr_r;
    assign avm_read           = read_r;
    assign dout_valid         = valid_r;
    assign dout_data          = data_r;
    assign dout_startofpacket = sop_r;
    assign dout_endofpacket   = eop_r;
    assign sig_busy           = busy_r;

endmodule
